pw_writer: RTL
==============

Name: pw_writer

Overview:
Password programming block for the pushbutton password-detection design. It takes the four debounced pushbutton levels, captures a PW_LEN-digit sequence while programming mode is enabled, and atomically commits it to the stored-password register read by the checker. Old password is kept on any aborted entry.

Parameters:
PW_LEN, 4, number of digits per password (2..8)
TIMEOUT_CYC, 100_000_000, max clkin cycles between presses before abort (1 s at 100 MHz)
DEFAULT_PW, 8'b00_01_10_11, reset password, 2 bits per digit, first digit in MSBs (A,B,C,D)

Ports:
clkin  in  1  system clock
reset  in  1  asynchronous, active-low reset
prog_en  in  1  level; high = programming mode requested
a  in  1  debounced button A level (code 2'b00)
b  in  1  debounced button B level (code 2'b01)
c  in  1  debounced button C level (code 2'b10)
d  in  1  debounced button D level (code 2'b11)
pw_out  out  2*PW_LEN  committed password, first digit in MSBs
busy  out  1  high while in ARM or CAPTURE
digit_cnt  out  3  digits captured so far in current entry
done  out  1  one-cycle pulse on successful commit
error  out  1  one-cycle pulse on abort

Behaviour:
- Reset (reset=0, async): pw_out=DEFAULT_PW, shadow=0, digit_cnt=0, busy=0, done=0, error=0, timer=0, state=IDLE, edge-detect history regs=0.
- Edge detect: registered copy of a..d; press = level 1 & prev 0. Exactly one press in a cycle -> valid digit with its code. Two or more presses same cycle -> multi-press.
- States:
  - IDLE: busy=0. prog_en=1 -> ARM.
  - ARM: busy=1; wait until a..d all 0 (avoids capturing a held button); then -> CAPTURE, digit_cnt=0, timer=0. prog_en=0 -> IDLE, no pulse.
  - CAPTURE: busy=1. Valid digit -> shadow shifts left 2, code into LSBs, digit_cnt+1, timer=0. When this is digit PW_LEN -> COMMIT. No press -> timer+1.
  - COMMIT: one cycle; pw_out<=shadow, done=1, digit_cnt=0 -> IDLE (prog_en still high does not re-arm until it goes 0 then 1).
- Abort conditions in CAPTURE (error=1 for one cycle, pw_out unchanged, shadow and digit_cnt cleared, -> IDLE): timer reaches TIMEOUT_CYC-1; multi-press; prog_en falls.
- Simultaneous events: abort outranks digit capture in the same cycle; prog_en fall and final digit in the same cycle -> abort, no commit.
- Re-arm after done or error requires prog_en low for at least one cycle (registered prog_en edge).
- Latency: button rising edge at cycle n -> digit_cnt updates at n+1 (one cycle edge register); final digit -> pw_out and done at n+2.
- done and error never high together. pw_out changes only in COMMIT or reset.
- Async reset mid-capture returns pw_out to DEFAULT_PW (not the last committed value).

Decomposition:
- Shared package: button code constants (BTN_A..BTN_D = 2'b00..2'b11), state encoding (IDLE, ARM, CAPTURE, COMMIT), DEFAULT_PW constant shared with the checker.
- One sub-module: pw_edge_det (4-bit rising-edge detector with one-hot-to-code encoder and multi-press flag); timer and FSM stay in pw_writer.

Test Plan:
- Reset, then prog_en=1, press B,D,A,C one per 10 cycles -> done pulse, pw_out=8'b01_11_00_10, digit_cnt back to 0, error never asserted.
- Enter prog_en=1 with A held -> remains in ARM (busy=1, digit_cnt=0) until A released; a later press of A counts as digit 1.
- Press A,B then idle TIMEOUT_CYC cycles (set to 50 in bench) -> error pulse at cycle 50 after last press, pw_out still 8'b00_01_10_11.
- After one digit, press C and D in the same cycle -> error pulse, no digit captured, pw_out unchanged, state IDLE.
- Three digits entered, then drop prog_en coincident with 4th press -> error pulse, no done, pw_out unchanged; raise prog_en again -> fresh entry from digit_cnt=0.
- Commit 8'b11_11_11_11, then assert reset low mid-way through a new entry -> pw_out=8'b00_01_10_11 immediately (async), all outputs at reset values.

Source files
------------

// File: rtl/pw_pkg.sv
// Shared definitions for the pushbutton password design: button codes,
// writer state encoding and the power-on password also used by the checker.
package pw_pkg;

   localparam logic [1:0] BTN_A = 2'b00;
   localparam logic [1:0] BTN_B = 2'b01;
   localparam logic [1:0] BTN_C = 2'b10;
   localparam logic [1:0] BTN_D = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARM     = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_COMMIT  = 2'd3
   } state_t;

   // Digits A,B,C,D with the first digit in the MSBs.
   localparam logic [7:0] DEFAULT_PW = 8'b00_01_10_11;

endpackage

// File: rtl/pw_edge_det.sv
// Registered rising-edge detector for the four buttons: reports a single
// press with its code, or a multi-press when two or more buttons rise together.
module pw_edge_det
   import pw_pkg::*;
(
   input  logic       clkin,
   input  logic       reset,
   input  logic [3:0] btn,
   output logic       valid,
   output logic [1:0] code,
   output logic       multi
);

   logic [3:0] prev_reg;
   logic [3:0] press;
   logic [1:0] code_next;
   logic       one_next;
   logic       multi_next;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_press
         assign press[gi] = btn[gi] & ~prev_reg[gi];
      end
   endgenerate

   always_comb begin
      code_next  = BTN_A;
      one_next   = 1'b0;
      multi_next = 1'b0;
      case (press)
         4'b0000: ;
         4'b0001: begin code_next = BTN_A; one_next = 1'b1; end
         4'b0010: begin code_next = BTN_B; one_next = 1'b1; end
         4'b0100: begin code_next = BTN_C; one_next = 1'b1; end
         4'b1000: begin code_next = BTN_D; one_next = 1'b1; end
         default: multi_next = 1'b1;
      endcase
   end

   always_ff @(posedge clkin or negedge reset) begin
      if (!reset) begin
         prev_reg <= 4'b0000;
         valid    <= 1'b0;
         code     <= BTN_A;
         multi    <= 1'b0;
      end else begin
         prev_reg <= btn;
         valid    <= one_next;
         code     <= code_next;
         multi    <= multi_next;
      end
   end

endmodule

// File: rtl/pw_writer.sv
// Password programming block: captures PW_LEN button digits while prog_en is
// high and commits them atomically to pw_out; any aborted entry keeps the old value.
module pw_writer
   import pw_pkg::*;
#(
   parameter int                    PW_LEN      = 4,
   parameter int                    TIMEOUT_CYC = 100_000_000,
   parameter logic [2*PW_LEN-1:0]   DEFAULT_PW  = pw_pkg::DEFAULT_PW
) (
   input  logic                  clkin,
   input  logic                  reset,
   input  logic                  prog_en,
   input  logic                  a,
   input  logic                  b,
   input  logic                  c,
   input  logic                  d,
   output logic [2*PW_LEN-1:0]   pw_out,
   output logic                  busy,
   output logic [2:0]            digit_cnt,
   output logic                  done,
   output logic                  error
);

   localparam int               TW       = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0]    TIMER_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [2:0]       CNT_LAST = 3'(PW_LEN - 1);

   state_t                state_reg;
   logic [2*PW_LEN-1:0]   shadow_reg;
   logic [TW-1:0]         timer_reg;
   logic                  prog_prev_reg;
   logic                  press_valid;
   logic [1:0]            press_code;
   logic                  press_multi;

   pw_edge_det u_edge (
      .clkin (clkin),
      .reset (reset),
      .btn   ({d, c, b, a}),
      .valid (press_valid),
      .code  (press_code),
      .multi (press_multi)
   );

   always_ff @(posedge clkin or negedge reset) begin
      if (!reset) begin
         state_reg     <= ST_IDLE;
         pw_out        <= DEFAULT_PW;
         shadow_reg    <= '0;
         timer_reg     <= '0;
         digit_cnt     <= 3'd0;
         busy          <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
         prog_prev_reg <= 1'b0;
      end else begin
         done          <= 1'b0;
         error         <= 1'b0;
         prog_prev_reg <= prog_en;
         case (state_reg)
            ST_IDLE: begin
               busy <= 1'b0;
               // Only a fresh rising edge arms, so a held prog_en cannot re-arm.
               if (prog_en && !prog_prev_reg) begin
                  state_reg <= ST_ARM;
                  busy      <= 1'b1;
               end
            end
            ST_ARM: begin
               if (!prog_en) begin
                  state_reg <= ST_IDLE;
                  busy      <= 1'b0;
               end else if (!(a | b | c | d)) begin
                  state_reg  <= ST_CAPTURE;
                  digit_cnt  <= 3'd0;
                  timer_reg  <= '0;
                  shadow_reg <= '0;
               end
            end
            ST_CAPTURE: begin
               // Abort conditions outrank a digit arriving in the same cycle.
               if (!prog_en || press_multi || timer_reg == TIMER_LAST) begin
                  state_reg  <= ST_IDLE;
                  busy       <= 1'b0;
                  error      <= 1'b1;
                  shadow_reg <= '0;
                  digit_cnt  <= 3'd0;
                  timer_reg  <= '0;
               end else if (press_valid) begin
                  shadow_reg <= {shadow_reg[2*PW_LEN-3:0], press_code};
                  digit_cnt  <= digit_cnt + 3'd1;
                  timer_reg  <= '0;
                  if (digit_cnt == CNT_LAST) begin
                     state_reg <= ST_COMMIT;
                     busy      <= 1'b0;
                  end
               end else begin
                  timer_reg <= timer_reg + TW'(1);
               end
            end
            ST_COMMIT: begin
               pw_out     <= shadow_reg;
               done       <= 1'b1;
               digit_cnt  <= 3'd0;
               shadow_reg <= '0;
               state_reg  <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule
